// File: rtl/lockin_pkg.sv
// Shared types and constants for the lock-in I/Q demodulator.
package lockin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_ADC_W = 14;
    localparam int DEF_NCO_W = 14;
    localparam int DEF_CNT_W = 24;
    localparam int DEF_ACC_W = DEF_ADC_W + DEF_NCO_W + DEF_CNT_W;

    // Saturation limits for a w-bit signed value (w <= 64), low w bits valid.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/lockin_iq_demod_mac.sv
// One-channel 2-stage signed multiply-accumulate with clear and enable.
// Saturating accumulation when LOCKIN_SATURATE_EN is defined, wrap otherwise.
module lockin_iq_demod_mac
    import lockin_pkg::*;
#(
    parameter int A_W   = DEF_ADC_W,
    parameter int B_W   = DEF_NCO_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc,
    output logic                    clip
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   a_x;
    logic signed [P_W-1:0]   b_x;
    logic signed [P_W-1:0]   prod;
    logic                    vld;
    logic signed [ACC_W-1:0] nxt;

    assign a_x = P_W'(a);
    assign b_x = P_W'(b);

`ifdef LOCKIN_SATURATE_EN
    localparam int S_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W:0] sum;
    logic                  hi;
    logic                  lo;

    // One guard bit: differing top two bits mean the add left the range.
    assign sum  = S_W'(acc) + S_W'(prod);
    assign hi   = ~sum[ACC_W] & sum[ACC_W-1];
    assign lo   = sum[ACC_W] & ~sum[ACC_W-1];
    assign nxt  = hi ? MAX_V : (lo ? MIN_V : sum[ACC_W-1:0]);
    assign clip = vld & (hi | lo);
`else
    assign nxt  = acc + ACC_W'(prod);
    assign clip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod <= '0;
            vld  <= 1'b0;
            acc  <= '0;
        end else if (clr) begin
            prod <= '0;
            vld  <= 1'b0;
            acc  <= '0;
        end else begin
            prod <= a_x * b_x;
            vld  <= en;
            if (vld) begin
                acc <= nxt;
            end
        end
    end

endmodule

// File: rtl/lockin_iq_demod.sv
// Lock-in I/Q demodulator: settle, accumulate adc*cos and adc*sin, report sums.
// Define LOCKIN_SATURATE_EN for saturating accumulators and a live overrange flag.
module lockin_iq_demod
    import lockin_pkg::*;
#(
    parameter int ADC_W = DEF_ADC_W,
    parameter int NCO_W = DEF_NCO_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic [CNT_W-1:0]        settle_cycles,
    input  logic signed [ADC_W-1:0] adc_i,
    input  logic                    adc_valid,
    input  logic signed [NCO_W-1:0] fsin_i,
    input  logic signed [NCO_W-1:0] fcos_i,
    input  logic                    nco_valid,
    output logic                    busy,
    output logic signed [ACC_W-1:0] i_acc_o,
    output logic signed [ACC_W-1:0] q_acc_o,
    output logic                    result_valid,
    output logic                    overrange
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        n_lat;
    logic [CNT_W-1:0]        settle_lat;
    logic                    accept;
    logic                    go;
    logic                    clr;
    logic                    mac_en;
    logic                    cnt_inc;
    logic                    fin;
    logic                    clip_i;
    logic                    clip_q;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;

    assign accept = adc_valid & nco_valid;
    assign go     = (state == IDLE) & start & ~abort;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        mac_en   = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    clr = 1'b1;
                    if (n_samples == '0) begin
                        state_nx = DONE;
                    end else if (settle_cycles == '0) begin
                        state_nx = ACCUM;
                    end else begin
                        state_nx = SETTLE;
                    end
                end
            end
            SETTLE: begin
                cnt_inc = accept;
                if (accept && cnt == settle_lat - ONE) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                cnt_inc = accept;
                mac_en  = accept;
                if (accept && cnt == n_lat - ONE) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                cnt_inc = 1'b1;
                if (cnt == ONE) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            clr      = 1'b1;
            mac_en   = 1'b0;
        end
    end

    // fin adds the extra edge between DONE and the visible result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            n_lat        <= '0;
            settle_lat   <= '0;
            fin          <= 1'b0;
            result_valid <= 1'b0;
            i_acc_o      <= '0;
            q_acc_o      <= '0;
            overrange    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + {{(CNT_W-1){1'b0}}, cnt_inc};
            end
            if (go) begin
                n_lat      <= n_samples;
                settle_lat <= settle_cycles;
            end
            fin          <= (state == DONE) & ~abort;
            result_valid <= fin;
            if (fin) begin
                i_acc_o <= acc_i;
                q_acc_o <= acc_q;
            end
            if (go) begin
                overrange <= 1'b0;
            end else if (clip_i | clip_q) begin
                overrange <= 1'b1;
            end
        end
    end

    lockin_iq_demod_mac #(
        .A_W   (ADC_W),
        .B_W   (NCO_W),
        .ACC_W (ACC_W)
    ) u_mac_i (
        .clk  (clk),
        .rst  (reset),
        .clr  (clr),
        .en   (mac_en),
        .a    (adc_i),
        .b    (fcos_i),
        .acc  (acc_i),
        .clip (clip_i)
    );

    lockin_iq_demod_mac #(
        .A_W   (ADC_W),
        .B_W   (NCO_W),
        .ACC_W (ACC_W)
    ) u_mac_q (
        .clk  (clk),
        .rst  (reset),
        .clr  (clr),
        .en   (mac_en),
        .a    (adc_i),
        .b    (fsin_i),
        .acc  (acc_q),
        .clip (clip_q)
    );

endmodule

// File: tb/tb_lockin_iq_demod.sv
// Scoreboard bench for lockin_iq_demod (ACC_W=30 so saturation is reachable).
// Expected sums are hand-computed; a monitor checks each result_valid pulse.
module tb_lockin_iq_demod;

    localparam int ADC_W = 14;
    localparam int NCO_W = 14;
    localparam int CNT_W = 24;
    localparam int ACC_W = 30;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        n_samples;
    logic [CNT_W-1:0]        settle_cycles;
    logic signed [ADC_W-1:0] adc_i;
    logic                    adc_valid;
    logic signed [NCO_W-1:0] fsin_i;
    logic signed [NCO_W-1:0] fcos_i;
    logic                    nco_valid;
    logic                    busy;
    logic signed [ACC_W-1:0] i_acc_o;
    logic signed [ACC_W-1:0] q_acc_o;
    logic                    result_valid;
    logic                    overrange;

    typedef struct {
        string              nm;
        logic signed [63:0] i;
        logic signed [63:0] q;
        logic               ovr;
        int                 at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   last;
    bit   ok;

    lockin_iq_demod #(
        .ADC_W (ADC_W),
        .NCO_W (NCO_W),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .n_samples     (n_samples),
        .settle_cycles (settle_cycles),
        .adc_i         (adc_i),
        .adc_valid     (adc_valid),
        .fsin_i        (fsin_i),
        .fcos_i        (fcos_i),
        .nco_valid     (nco_valid),
        .busy          (busy),
        .i_acc_o       (i_acc_o),
        .q_acc_o       (q_acc_o),
        .result_valid  (result_valid),
        .overrange     (overrange)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n, input int s);
        n_samples     = CNT_W'(n);
        settle_cycles = CNT_W'(s);
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic pair(input int a, input int c, input int s, input bit v);
        adc_i     = ADC_W'(a);
        fcos_i    = NCO_W'(c);
        fsin_i    = NCO_W'(s);
        adc_valid = v;
        nco_valid = 1'b1;
        tick();
    endtask

    task automatic push(input string nm, input longint i, input longint q,
                        input bit o, input int at);
        exp_t e;
        e.nm  = nm;
        e.i   = i;
        e.q   = q;
        e.ovr = o;
        e.at  = at;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        adc_valid = 1'b0;
        for (int k = 0; k < 200 && busy; k++) tick();
        chk({nm, "_idle_timeout"}, busy, 0);
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (!reset && result_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: i=%0d q=%0d required none",
                         i_acc_o, q_acc_o);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_i"}, i_acc_o, mon_e.i);
                chk({mon_e.nm, "_q"}, q_acc_o, mon_e.q);
                chk({mon_e.nm, "_ovr"}, overrange, mon_e.ovr);
                chk({mon_e.nm, "_lat"}, cyc, mon_e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        n_samples     = '0;
        settle_cycles = '0;
        adc_i         = '0;
        adc_valid     = 1'b0;
        fsin_i        = '0;
        fcos_i        = '0;
        nco_valid     = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_ovr", overrange, 0);
        chk("rst_i", i_acc_o, 0);
        chk("rst_q", q_acc_o, 0);
        reset = 1'b0;
        tick();

        // Constant input, extra valid pairs after the 4th must be ignored.
        go(4, 0);
        for (int k = 0; k < 4; k++) pair(1000, 8191, 0, 1'b1);
        push("t1", 32764000, 0, 1'b0, cyc + 4);
        for (int k = 0; k < 3; k++) pair(1000, 8191, 0, 1'b1);
        wait_idle("t1");

        // Three settle pairs discarded.
        go(2, 3);
        pair(5, 1, -1, 1'b1);
        pair(5, 1, -1, 1'b1);
        pair(5, 1, -1, 1'b1);
        pair(7, 1, -1, 1'b1);
        pair(9, 1, -1, 1'b1);
        push("t2", 16, -16, 1'b0, cyc + 4);
        wait_idle("t2");

        // adc_valid toggling; junk on invalid cycles.
        go(8, 0);
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) pair(10 * (k / 2 + 1), 3, -2, 1'b1);
            else            pair(999, 3, -2, 1'b0);
            if (k == 14) last = cyc;
            if (!busy) ok = 1'b0;
        end
        push("t3", 1080, -720, 1'b0, last + 4);
        chk("t3_busy", ok, 1);
        wait_idle("t3");

        // Abort after 3 of 10 pairs.
        go(10, 0);
        for (int k = 0; k < 3; k++) pair(50, 1, 1, 1'b1);
        abort     = 1'b1;
        adc_valid = 1'b0;
        tick();
        abort     = 1'b0;
        chk("t4_abort_busy", busy, 0);
        repeat (6) tick();
        chk("t4_hold_i", i_acc_o, 1080);
        chk("t4_hold_q", q_acc_o, -720);
        go(2, 1);
        pair(4, 2, 5, 1'b1);
        pair(6, 2, 5, 1'b1);
        pair(8, 2, 5, 1'b1);
        push("t4_rerun", 28, 70, 1'b0, cyc + 4);
        wait_idle("t4");

        // n_samples == 0.
        go(0, 0);
        push("t5_zero", 0, 0, 1'b0, cyc + 2);
        wait_idle("t5");

        // Start while busy must not re-sample parameters.
        go(3, 0);
        pair(2, 1, 1, 1'b1);
        start         = 1'b1;
        n_samples     = CNT_W'(100);
        settle_cycles = CNT_W'(5);
        pair(2, 1, 1, 1'b1);
        start         = 1'b0;
        pair(2, 1, 1, 1'b1);
        push("t5_busy_start", 6, 6, 1'b0, cyc + 4);
        wait_idle("t5b");

        // 20 * 2^26 exceeds a 30-bit accumulator.
        go(20, 0);
        for (int k = 0; k < 20; k++) pair(-8192, 0, -8192, 1'b1);
`ifdef LOCKIN_SATURATE_EN
        push("t6_sat", 0, 536870911, 1'b1, cyc + 4);
`else
        push("t6_wrap", 0, 268435456, 1'b0, cyc + 4);
`endif
        wait_idle("t6");

        // overrange cleared by the next start.
        go(1, 0);
        pair(1, 1, 1, 1'b1);
        push("t6_clear", 1, 1, 1'b0, cyc + 4);
        wait_idle("t6c");

        repeat (10) tick();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
